// File: rtl/alu_cmd_issuer.sv
// Request-side issuer for the four-operand 8-bit ALU: registers one operation at a
// time onto the ALU, captures its result into a response FIFO, counts ops, flags zero mismatches.
module alu_cmd_issuer #(
  parameter int RSP_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [7:0]       req_c,
  input  logic [7:0]       req_d,
  input  logic             req_sel,
  output logic [3:0]       alu_opcode,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [7:0]       alu_c,
  output logic [7:0]       alu_d,
  output logic             alu_sel,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count,
  output logic             zero_err
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state_q;
  logic [3:0]        alu_opcode_q;
  logic [7:0]        alu_a_q;
  logic [7:0]        alu_b_q;
  logic [7:0]        alu_c_q;
  logic [7:0]        alu_d_q;
  logic              alu_sel_q;
  logic [CNT_W-1:0]  op_count_q;
  logic [CNT_W-1:0]  op_count_d;
  logic              zero_err_q;
  logic              zero_err_d;

  logic [8:0]        mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;

  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              accept_s;
  logic              ready_s;
  logic              mismatch_s;

  // Handshake, FIFO occupancy and capture bookkeeping.
  always_comb begin
    full_s     = (level_q == LVL_W'(RSP_DEPTH));
    push_s     = (state_q == EXEC);
    pop_s      = (level_q != LVL_W'(0)) && rsp_ready;
    ready_s    = 1'b0;
    mismatch_s = (alu_zero != (alu_result == 8'd0));
    if (state_q == IDLE && !rst) begin
      // A slot freed by a same-cycle pop counts as free.
      ready_s = !full_s || rsp_ready;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = req_valid && ready_s;

    level_d = level_q;
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_s && pop_s) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end

    if (push_s) begin
      op_count_d = op_count_q + CNT_W'(1);
      zero_err_d = zero_err_q || mismatch_s;
    end else begin
      op_count_d = op_count_q;
      zero_err_d = zero_err_q;
    end
  end

  // Issue FSM with the registered ALU drive, op counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_opcode_q <= 4'd0;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      alu_c_q      <= 8'd0;
      alu_d_q      <= 8'd0;
      alu_sel_q    <= 1'b0;
      op_count_q   <= '0;
      zero_err_q   <= 1'b0;
    end else begin
      op_count_q <= op_count_d;
      zero_err_q <= zero_err_d;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            alu_opcode_q <= req_opcode;
            alu_a_q      <= req_a;
            alu_b_q      <= req_b;
            alu_c_q      <= req_c;
            alu_d_q      <= req_d;
            alu_sel_q    <= req_sel;
            state_q      <= EXEC;
          end else begin
            state_q      <= IDLE;
          end
        end
        EXEC: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Response FIFO storage and pointers; entry is {zero, result}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= 9'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= {alu_zero, alu_result};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign req_ready  = ready_s;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_c      = alu_c_q;
  assign alu_d      = alu_d_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = (level_q != LVL_W'(0));
  assign rsp_result = mem_q[rd_ptr_q][7:0];
  assign rsp_zero   = mem_q[rd_ptr_q][8];
  assign op_count   = op_count_q;
  assign zero_err   = zero_err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU; each scenario task checks inline.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic [7:0]  req_a, req_b, req_c, req_d;
  logic        req_sel;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_c, alu_d;
  logic        alu_sel;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic [15:0] op_count;
  logic        zero_err;
  logic        force_bad;

  int tests;
  int fails;

  alu_cmd_issuer #(.RSP_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d), .req_sel(req_sel),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
    .alu_sel(alu_sel), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .op_count(op_count), .zero_err(zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; force_bad inverts the zero flag to provoke zero_err.
  always_comb begin
    case (alu_opcode)
      4'd0, 4'd7: alu_result = alu_a + alu_b + alu_c + alu_d;
      4'd1:       alu_result = alu_a - alu_b;
      4'd2:       alu_result = alu_a & alu_b;
      4'd3:       alu_result = alu_a | alu_b;
      4'd4:       alu_result = alu_a ^ alu_b;
      4'd5:       alu_result = ~alu_a;
      4'd6:       alu_result = alu_sel ? (alu_a + alu_c) : (alu_b + alu_d);
      default:    alu_result = 8'd0;
    endcase
    alu_zero = (alu_result == 8'd0) ^ force_bad;
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d, input logic sel);
    bit done;
    done = 1'b0;
    req_opcode = op; req_a = a; req_b = b; req_c = c; req_d = d; req_sel = sel;
    req_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: req_ready got 0 for 20 cycles, wanted 1");
    end
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({alu_opcode, alu_a, alu_b, alu_c, alu_d, alu_sel} !== 37'd0) begin
      fails++; $display("FAIL reset_alu: got %h, wanted 0", {alu_opcode, alu_a, alu_b, alu_c, alu_d, alu_sel});
    end
    tests++;
    if ({rsp_valid, rsp_result, rsp_zero, op_count, zero_err, req_ready} !== 28'd0) begin
      fails++; $display("FAIL reset_rsp: valid=%b res=%h zero=%b cnt=%0d err=%b rdy=%b, wanted all 0",
                        rsp_valid, rsp_result, rsp_zero, op_count, zero_err, req_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_after: got %b, wanted 1", req_ready);
    end
  endtask

  task automatic test_add();
    send(4'd0, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    tests++;
    if (alu_opcode !== 4'd0 || alu_a !== 8'd1 || alu_d !== 8'd4 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL add_exec: op=%h a=%h d=%h rdy=%b valid=%b, wanted 0 01 04 0 0",
                        alu_opcode, alu_a, alu_d, req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'd10 || rsp_zero !== 1'b0 || op_count !== 16'd1) begin
      fails++; $display("FAIL add_rsp: valid=%b res=%0d zero=%b cnt=%0d, wanted 1 10 0 1",
                        rsp_valid, rsp_result, rsp_zero, op_count);
    end
    pop_one();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL add_pop: rsp_valid=%b, wanted 0", rsp_valid);
    end
  endtask

  task automatic test_sub_zero();
    send(4'd1, 8'd5, 8'd5, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'd0 || rsp_zero !== 1'b1) begin
      fails++; $display("FAIL sub_zero: valid=%b res=%h zero=%b, wanted 1 00 1", rsp_valid, rsp_result, rsp_zero);
    end
    pop_one();
    send(4'd9, 8'd7, 8'd8, 8'd9, 8'd10, 1'b1);
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'd0 || rsp_zero !== 1'b1 || op_count !== 16'd3 || alu_opcode !== 4'd9) begin
      fails++; $display("FAIL op9: valid=%b res=%h zero=%b cnt=%0d op=%h, wanted 1 00 1 3 9",
                        rsp_valid, rsp_result, rsp_zero, op_count, alu_opcode);
    end
    pop_one();
  endtask

  task automatic test_sel_order();
    send(4'd6, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    send(4'd6, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'd4) begin
      fails++; $display("FAIL sel_first: valid=%b res=%0d, wanted 1 4", rsp_valid, rsp_result);
    end
    pop_one();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'd6 || op_count !== 16'd5) begin
      fails++; $display("FAIL sel_second: valid=%b res=%0d cnt=%0d, wanted 1 6 5", rsp_valid, rsp_result, op_count);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; #1; rst = 1'b0; #1;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'd0, 8'(i), 8'd0, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    req_opcode = 4'd0; req_a = 8'd5; req_b = 8'd0; req_c = 8'd0; req_d = 8'd0; req_sel = 1'b0;
    req_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (req_ready !== 1'b0 || op_count !== 16'd4 || rsp_result !== 8'd1 || rsp_valid !== 1'b1) begin
      fails++; $display("FAIL full_hold: rdy=%b cnt=%0d res=%0d valid=%b, wanted 0 4 1 1",
                        req_ready, op_count, rsp_result, rsp_valid);
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL full_pop_credit: req_ready=%b, wanted 1", req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'(k)) begin
        fails++; $display("FAIL drain_%0d: valid=%b res=%0d, wanted 1 %0d", k, rsp_valid, rsp_result, k);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd5) begin
      fails++; $display("FAIL drain_end: valid=%b cnt=%0d, wanted 0 5", rsp_valid, op_count);
    end
  endtask

  task automatic test_wrap_zero_err();
    send(4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (rsp_result !== 8'h00 || rsp_zero !== 1'b1 || zero_err !== 1'b0) begin
      fails++; $display("FAIL add_wrap: res=%h zero=%b err=%b, wanted 00 1 0", rsp_result, rsp_zero, zero_err);
    end
    pop_one();
    force_bad = 1'b1;
    send(4'd0, 8'd1, 8'd1, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    force_bad = 1'b0;
    tests++;
    if (zero_err !== 1'b1 || rsp_result !== 8'd2) begin
      fails++; $display("FAIL zero_err_set: err=%b res=%0d, wanted 1 2", zero_err, rsp_result);
    end
    pop_one();
    send(4'd0, 8'd1, 8'd2, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (zero_err !== 1'b1 || rsp_result !== 8'd3) begin
      fails++; $display("FAIL zero_err_sticky: err=%b res=%0d, wanted 1 3", zero_err, rsp_result);
    end
  endtask

  task automatic test_reset_mid_exec();
    send(4'd0, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    rst = 1'b1;
    #1;
    tests++;
    if ({alu_opcode, alu_a, alu_b, alu_c, alu_d, alu_sel} !== 37'd0 || rsp_valid !== 1'b0 ||
        rsp_result !== 8'd0 || op_count !== 16'd0 || zero_err !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL rst_exec: a=%h valid=%b res=%h cnt=%0d err=%b rdy=%b, wanted 0 0 00 0 0 0",
                        alu_a, rsp_valid, rsp_result, op_count, zero_err, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL rst_exec_after: valid=%b cnt=%0d rdy=%b, wanted 0 0 1", rsp_valid, op_count, req_ready);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; force_bad = 1'b0;
    req_opcode = 4'd0; req_a = 8'd0; req_b = 8'd0; req_c = 8'd0; req_d = 8'd0; req_sel = 1'b0;
    test_reset();
    test_add();
    test_sub_zero();
    test_sel_order();
    test_back_to_back();
    test_wrap_zero_err();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
